// File: rtl/fetch_stage_pkg.sv
// Shared types for the fetch stage: the fetch-to-decode payload and the fetch FSM states.
package fetch_stage_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instruction_value;
    logic [31:0] pc_value;
    logic        pc_r;
  } fe_to_de_s;

  typedef enum logic [1:0] {
    REFILL = 2'd0,
    RUN    = 2'd1,
    HOLD   = 2'd2
  } fetch_state_e;

  function automatic fe_to_de_s make_fe(input logic [31:0] instr,
                                        input logic [31:0] pc,
                                        input logic        bubble);
    fe_to_de_s f;
    f.instruction_value = instr;
    f.pc_value          = pc;
    f.pc_r              = bubble;
    return f;
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry capture register for the instruction word returned while the pipeline is stalled.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] new_instr,
  input  logic [31:0] new_pc,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr <= 32'h0;
      pc    <= 32'h0;
    end else if (clear) begin
      instr <= 32'h0;
      pc    <= 32'h0;
    end else if (load) begin
      instr <= new_instr;
      pc    <= new_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, drives a 1-cycle synchronous instruction memory,
// buffers the returned word across stalls and turns redirects into bubbles.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        pc_r,
  input  logic [31:0] pc_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output fe_to_de_s   fe_to_de
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc_f, resp_pc, hold_instr, hold_pc, target_aligned;
  logic         advance, hold_load;

  assign target_aligned = pc_target & 32'hFFFF_FFFC;
  assign imem_addr      = pc_f;
  assign advance        = !pc_r && ((state == REFILL) || en);
  assign hold_load      = (state == RUN) && !en && !pc_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= REFILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (pc_r) begin
      state_nxt = REFILL;
    end else begin
      case (state)
        REFILL:  state_nxt = RUN;
        RUN:     if (!en) state_nxt = HOLD;
        HOLD:    if (en) state_nxt = RUN;
        default: state_nxt = REFILL;
      endcase
    end
  end

  always_comb begin
    imem_req = 1'b0;
    if (!reset) begin
      case (state)
        REFILL, RUN: imem_req = 1'b1;
        HOLD:        imem_req = en;
        default:     imem_req = 1'b0;
      endcase
    end
  end

  // Redirect outranks everything: in-flight data and the held word are simply never forwarded.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_f     <= RESET_PC;
      resp_pc  <= RESET_PC;
      fe_to_de <= make_fe(NOP_INSTR, RESET_PC, 1'b1);
    end else if (pc_r) begin
      pc_f     <= target_aligned;
      fe_to_de <= make_fe(NOP_INSTR, resp_pc, 1'b1);
    end else begin
      if (advance) begin
        resp_pc <= pc_f;
        pc_f    <= pc_f + 32'd4;
      end
      case (state)
        REFILL:  if (en) fe_to_de <= make_fe(NOP_INSTR, resp_pc, 1'b1);
        RUN:     if (en) fe_to_de <= make_fe(imem_rdata, resp_pc, 1'b0);
        HOLD:    if (en) fe_to_de <= make_fe(hold_instr, hold_pc, 1'b0);
        default: fe_to_de <= make_fe(NOP_INSTR, resp_pc, 1'b1);
      endcase
    end
  end

  fetch_hold_buf u_hold (
    .clk       (clk),
    .reset     (reset),
    .load      (hold_load),
    .clear     (pc_r),
    .new_instr (imem_rdata),
    .new_pc    (resp_pc),
    .instr     (hold_instr),
    .pc        (hold_pc)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run against a stream model.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset = 1'b1, en = 1'b1, pc_r = 1'b0;
  logic [31:0] pc_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr, imem_rdata;
  fe_to_de_s   fe;

  logic        reset_w = 1'b1, en_w = 1'b1, pc_r_w = 1'b0;
  logic [31:0] pc_target_w = 32'h0;
  logic        imem_req_w;
  logic [31:0] imem_addr_w, imem_rdata_w;
  fe_to_de_s   fe_w;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .en(en), .pc_r(pc_r), .pc_target(pc_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .fe_to_de(fe)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset_w), .en(en_w), .pc_r(pc_r_w), .pc_target(pc_target_w),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_rdata(imem_rdata_w), .fe_to_de(fe_w)
  );

  // Memory contents: the word at byte address A is A/4.
  always @(posedge clk) begin
    if (imem_req)   imem_rdata   <= imem_addr >> 2;
    if (imem_req_w) imem_rdata_w <= imem_addr_w >> 2;
  end

  function automatic fe_to_de_s fe_exp(input logic [31:0] instr, input logic [31:0] pc, input logic bub);
    fe_to_de_s f;
    f.instruction_value = instr;
    f.pc_value = pc;
    f.pc_r = bub;
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    fe_to_de_s e;
    reset = 1'b1; en = 1'b1; pc_r = 1'b0;
    #12;
    e = fe_exp(NOP, 32'h0, 1'b1);
    n_cmp++;
    if (fe !== e) begin n_err++; $display("FAIL reset_out: got %h want %h", fe, e); end
    n_cmp++;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", imem_req); end
    reset = 1'b0;
    step();
    n_cmp++;
    if (fe.pc_r !== 1'b1 || fe.instruction_value !== NOP) begin
      n_err++; $display("FAIL first_bubble: got %h want bubble", fe);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      e = fe_exp(i, 32'(i * 4), 1'b0);
      n_cmp++;
      if (fe !== e) begin n_err++; $display("FAIL stream%0d: got %h want %h", i, fe, e); end
    end
  endtask

  task automatic test_stall();
    fe_to_de_s e;
    en = 1'b0;
    e = fe_exp(32'h1, 32'h4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (fe !== e) begin n_err++; $display("FAIL stall_frozen%0d: got %h want %h", i, fe, e); end
      n_cmp++;
      if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req%0d: got %b want 0", i, imem_req); end
    end
    en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      e = fe_exp(32'(i + 2), 32'(8 + i * 4), 1'b0);
      n_cmp++;
      if (fe !== e) begin n_err++; $display("FAIL stall_release%0d: got %h want %h", i, fe, e); end
    end
  endtask

  task automatic test_redirect();
    fe_to_de_s e;
    pc_r = 1'b1; pc_target = 32'h100;
    step();
    pc_r = 1'b0;
    n_cmp++;
    if (imem_addr !== 32'h100) begin n_err++; $display("FAIL redir_addr: got %h want 00000100", imem_addr); end
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (fe.pc_r !== 1'b1 || fe.instruction_value !== NOP) begin
        n_err++; $display("FAIL redir_bubble%0d: got %h want bubble", i, fe);
      end
      if (i == 0) step();
    end
    for (int i = 0; i < 2; i++) begin
      step();
      e = fe_exp(32'(32'h40 + i), 32'(32'h100 + i * 4), 1'b0);
      n_cmp++;
      if (fe !== e) begin n_err++; $display("FAIL redir_stream%0d: got %h want %h", i, fe, e); end
    end
  endtask

  task automatic test_redirect_hold();
    fe_to_de_s e;
    en = 1'b0;
    step();
    n_cmp++;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL hold_req: got %b want 0", imem_req); end
    pc_r = 1'b1; pc_target = 32'h203;
    step();
    pc_r = 1'b0;
    n_cmp++;
    if (imem_addr !== 32'h200) begin n_err++; $display("FAIL hold_redir_addr: got %h want 00000200", imem_addr); end
    n_cmp++;
    if (fe.pc_r !== 1'b1 || fe.instruction_value !== NOP) begin
      n_err++; $display("FAIL hold_redir_bubble: got %h want bubble", fe);
    end
    en = 1'b1;
    step();
    n_cmp++;
    if (fe.pc_r !== 1'b1) begin n_err++; $display("FAIL hold_redir_bubble2: got %h want bubble", fe); end
    for (int i = 0; i < 2; i++) begin
      step();
      e = fe_exp(32'(32'h80 + i), 32'(32'h200 + i * 4), 1'b0);
      n_cmp++;
      if (fe !== e) begin n_err++; $display("FAIL hold_redir_stream%0d: got %h want %h", i, fe, e); end
    end
  endtask

  task automatic test_wrap();
    fe_to_de_s e;
    logic [31:0] pcs [3];
    pcs[0] = 32'hFFFF_FFF8; pcs[1] = 32'hFFFF_FFFC; pcs[2] = 32'h0;
    n_cmp++;
    if (fe_w !== fe_exp(NOP, 32'hFFFF_FFF8, 1'b1)) begin
      n_err++; $display("FAIL wrap_reset: got %h want bubble at fffffff8", fe_w);
    end
    reset_w = 1'b0;
    step();
    n_cmp++;
    if (fe_w.pc_r !== 1'b1) begin n_err++; $display("FAIL wrap_bubble: got %h want bubble", fe_w); end
    for (int i = 0; i < 3; i++) begin
      step();
      e = fe_exp(pcs[i] >> 2, pcs[i], 1'b0);
      n_cmp++;
      if (fe_w !== e) begin n_err++; $display("FAIL wrap%0d: got %h want %h", i, fe_w, e); end
    end
  endtask

  task automatic test_async_reset();
    fe_to_de_s e;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    e = fe_exp(NOP, 32'h0, 1'b1);
    n_cmp++;
    if (fe !== e) begin n_err++; $display("FAIL async_out: got %h want %h", fe, e); end
    n_cmp++;
    if (imem_req !== 1'b0) begin n_err++; $display("FAIL async_req: got %b want 0", imem_req); end
    step();
    n_cmp++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin
      n_err++; $display("FAIL async_hold: req %b addr %h want 0 00000000", imem_req, imem_addr);
    end
    reset = 1'b0;
    step();
    for (int i = 0; i < 2; i++) begin
      step();
      e = fe_exp(i, 32'(i * 4), 1'b0);
      n_cmp++;
      if (fe !== e) begin n_err++; $display("FAIL async_restart%0d: got %h want %h", i, fe, e); end
    end
  endtask

  // Stream model: valid words follow the current PC stream in order; a redirect
  // or reset costs one extra cycle before any word can be delivered.
  task automatic test_random();
    logic [31:0] m_next, m_instr, m_pc;
    bit m_refill, m_bub;
    @(posedge clk);
    #3 reset = 1'b1; en = 1'b1; pc_r = 1'b0;
    #4 reset = 1'b0;
    m_next = 32'h0; m_refill = 1'b1; m_instr = NOP; m_pc = 32'h0; m_bub = 1'b1;
    for (int c = 0; c < 600; c++) begin
      en = ($urandom % 4) != 0;
      pc_r = ($urandom % 14) == 0;
      pc_target = $urandom;
      if (pc_r) begin
        m_bub = 1'b1; m_instr = NOP; m_next = pc_target & 32'hFFFF_FFFC; m_refill = 1'b1;
      end else if (m_refill) begin
        m_refill = 1'b0;
        if (en) begin m_bub = 1'b1; m_instr = NOP; end
      end else if (en) begin
        m_bub = 1'b0; m_instr = m_next >> 2; m_pc = m_next; m_next = m_next + 32'd4;
      end
      step();
      n_cmp++;
      if (fe.pc_r !== m_bub || fe.instruction_value !== m_instr || (!m_bub && fe.pc_value !== m_pc)) begin
        n_err++;
        $display("FAIL rand_cycle%0d: got %h want instr %h pc %h bubble %b", c, fe, m_instr, m_pc, m_bub);
      end
      if (pc_r) begin
        n_cmp++;
        if (imem_addr !== m_next) begin
          n_err++; $display("FAIL rand_redir_addr%0d: got %h want %h", c, imem_addr, m_next);
        end
      end
    end
    pc_r = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect();
    test_redirect_hold();
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d compared %0d mismatched", n_cmp, n_err);
    $fatal(1);
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch pipeline stage; producer end of the fe_to_de_s interface consumed by the decode stage.
- Owns the fetch PC and drives a synchronous-read instruction memory with 1-cycle read latency.
- Captures the returned word into a hold buffer when the pipeline stalls, and absorbs PC redirects from execute by emitting bubbles (fe_to_de.pc_r=1).

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, instruction_value driven in bubbles (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  pipeline advance (same signal as decode en); 0 = stall.
- pc_r  in  1  redirect request from execute (taken branch/jump); qualifies pc_target.
- pc_target  in  32  redirect address; bits [1:0] ignored, forced to 0.
- imem_req  out  1  read request this cycle (combinational from state, en).
- imem_addr  out  32  read address = pc_f (combinational).
- imem_rdata  in  32  data for the request issued in the previous cycle.
- fe_to_de  out  fe_to_de_s  registered: instruction_value, pc_value, pc_r (1 = bubble).

Behaviour:
- Registers: pc_f (address requested this cycle), resp_pc (address whose data arrives this cycle), hold_instr, hold_pc, state, fe_to_de.
- Reset (async):
  - state=REFILL, pc_f=RESET_PC.
  - fe_to_de = {NOP_INSTR, RESET_PC, pc_r=1}.
  - imem_req=0 while reset is high.
- States:
  - REFILL: no valid response this cycle.
  - RUN: imem_rdata is valid for resp_pc.
  - HOLD: stalled; data sits in the hold buffer.
- Redirect (pc_r=1) has top priority in every state, regardless of en:
  - pc_f<={pc_target[31:2],2'b00}, state<=REFILL.
  - fe_to_de<=bubble (NOP_INSTR, pc_value=resp_pc, pc_r=1).
  - Any in-flight response or held word is discarded.
- REFILL (pc_r=0):
  - imem_req=1.
  - resp_pc<=pc_f, pc_f<=pc_f+4, state<=RUN.
  - If en, fe_to_de<=bubble; otherwise fe_to_de holds.
- RUN (pc_r=0):
  - imem_req=1.
  - en=1: fe_to_de<={imem_rdata, resp_pc, 0}; resp_pc<=pc_f; pc_f<=pc_f+4; stay RUN.
  - en=0: hold_instr<=imem_rdata, hold_pc<=resp_pc, state<=HOLD. pc_f unchanged; this cycle's request is dropped and reissued later. fe_to_de holds.
- HOLD (pc_r=0):
  - imem_req=en.
  - en=1: fe_to_de<={hold_instr, hold_pc, 0}; resp_pc<=pc_f; pc_f<=pc_f+4; state<=RUN.
  - en=0: all registers hold; imem_req=0.
- Latency: instruction at address A appears on fe_to_de two cycles after A is on imem_addr with en=1 throughout. A redirect costs two bubbles.
- No instruction is ever lost or duplicated across any sequence of stalls.
- Arithmetic: pc_f+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0).
- Simultaneous cases:
  - pc_r with en=0: redirect wins; bubble written.
  - pc_r in HOLD: hold buffer invalidated.
- Reset asserted mid-operation: immediately returns to reset values; pending data is discarded.
- Invariant: fe_to_de.pc_r=0 only for a word fetched from the current (post-redirect) PC stream.

Decomposition:
- Shared package (riscv_structures.sv):
  - fe_to_de_s (existing).
  - New enum fetch_state_e {REFILL, RUN, HOLD}.
  - Constant NOP_INSTR default.
- Sub-module fetch_hold_buf: 1-entry capture register (instr+pc, load/clear) separates the buffering from the PC FSM. Otherwise a single module.

Test Plan:
- Reset, RESET_PC=0, en=1, memory returns word at addr/4:
  - Cycle 1: fe_to_de bubble (pc_r=1).
  - Cycles 2,3,4: pc_value 0x0, 0x4, 0x8, pc_r=0.
- Stall: en=0 for 3 cycles while RUN holding 0x8:
  - fe_to_de frozen at 0x4.
  - imem_req=0 in HOLD.
  - After release: 0x8 then 0xC, no gap, no duplicate.
- Redirect: pc_r=1, pc_target=0x100 while streaming at 0x10:
  - Two bubbles (pc_r=1, instruction NOP_INSTR).
  - Then pc_value 0x100, 0x104.
  - imem_addr=0x100 the cycle after redirect.
- Redirect during HOLD (en=0, pc_r=1, target 0x203):
  - Held word discarded; imem_addr becomes 0x200.
  - First valid output pc_value=0x200.
- Wrap: RESET_PC=32'hFFFF_FFF8 -> valid pc_values 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Async reset pulse mid-stream (between clock edges):
  - fe_to_de immediately {NOP_INSTR, RESET_PC, pc_r=1}.
  - imem_req=0 while reset is high.
  - Fetch restarts at RESET_PC.
